// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, write-no-allocate cache controller
// sitting between the CPU sequencer and a synchronous single-port RAM.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req, req_we, req_addr,        CPU request strobe, store flag, word address,
//   req_wdata                     store data
//   ready                         combinational: idle and not flushing
//   ack, rdata, hit               registered completion pulse, load data, hit flag
//   flush                         invalidate all lines (honoured only in IDLE)
//   mem_addr, mem_cs, mem_we,     RAM address and control pins
//   mem_oe, mem_wdata, mem_rdata  RAM write data and read data
//   hit_count, miss_count         saturating performance counters
module cache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_WIDTH - INDEX_BITS;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MEM_RD   = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_MEM_WR   = 3'd4;

  logic [2:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  lookup_hit_q, lookup_hit_n;
  logic [LINES-1:0]      valid_q, valid_n;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic                  ack_n, hit_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic                  mem_cs_n, mem_we_n, mem_oe_n;
  logic [DATA_WIDTH-1:0] mem_wdata_n;
  logic [15:0]           hit_count_n, miss_count_n;

  logic                  line_we, tag_we;
  logic [DATA_WIDTH-1:0] line_wdata;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic                  cache_hit;
  logic                  accept;

  assign idx       = addr_q[INDEX_BITS-1:0];
  assign tag_in    = addr_q[ADDR_WIDTH-1:INDEX_BITS];
  assign cache_hit = valid_q[idx] && (tag_mem[idx] == tag_in);
  assign ready     = (state == S_IDLE) && !flush;
  assign accept    = req && ready;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    lookup_hit_n = lookup_hit_q;
    valid_n      = valid_q;
    ack_n        = 1'b0;
    hit_n        = hit;
    rdata_n      = rdata;
    mem_addr_n   = mem_addr;
    mem_cs_n     = mem_cs;
    mem_we_n     = mem_we;
    mem_oe_n     = mem_oe;
    mem_wdata_n  = mem_wdata;
    hit_count_n  = hit_count;
    miss_count_n = miss_count;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_wdata   = '0;

    case (state)
      S_IDLE: begin
        if (flush) begin
          valid_n = '0;
        end else if (req) begin
          state_n = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!we_q) begin
          if (cache_hit) begin
            ack_n       = 1'b1;
            hit_n       = 1'b1;
            rdata_n     = data_mem[idx];
            hit_count_n = sat_inc(hit_count);
            state_n     = S_IDLE;
          end else begin
            mem_addr_n   = addr_q;
            mem_cs_n     = 1'b1;
            mem_oe_n     = 1'b1;
            mem_we_n     = 1'b0;
            miss_count_n = sat_inc(miss_count);
            state_n      = S_MEM_RD;
          end
        end else begin
          mem_addr_n   = addr_q;
          mem_wdata_n  = wdata_q;
          mem_cs_n     = 1'b1;
          mem_we_n     = 1'b1;
          mem_oe_n     = 1'b0;
          lookup_hit_n = cache_hit;
          // Write-through: a store hit refreshes the line, a miss leaves the cache alone.
          if (cache_hit) begin
            line_we     = 1'b1;
            line_wdata  = wdata_q;
            hit_count_n = sat_inc(hit_count);
          end else begin
            miss_count_n = sat_inc(miss_count);
          end
          state_n = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        state_n = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        // RAM data for the address sampled last edge is on mem_rdata now.
        line_we      = 1'b1;
        line_wdata   = mem_rdata;
        tag_we       = 1'b1;
        valid_n[idx] = 1'b1;
        ack_n        = 1'b1;
        hit_n        = 1'b0;
        rdata_n      = mem_rdata;
        mem_cs_n     = 1'b0;
        mem_oe_n     = 1'b0;
        state_n      = S_IDLE;
      end
      S_MEM_WR: begin
        ack_n    = 1'b1;
        hit_n    = lookup_hit_q;
        mem_cs_n = 1'b0;
        mem_we_n = 1'b0;
        state_n  = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      lookup_hit_q <= 1'b0;
      valid_q      <= '0;
      ack          <= 1'b0;
      hit          <= 1'b0;
      rdata        <= '0;
      mem_addr     <= '0;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_oe       <= 1'b0;
      mem_wdata    <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state        <= state_n;
      lookup_hit_q <= lookup_hit_n;
      valid_q      <= valid_n;
      ack          <= ack_n;
      hit          <= hit_n;
      rdata        <= rdata_n;
      mem_addr     <= mem_addr_n;
      mem_cs       <= mem_cs_n;
      mem_we       <= mem_we_n;
      mem_oe       <= mem_oe_n;
      mem_wdata    <= mem_wdata_n;
      hit_count    <= hit_count_n;
      miss_count   <= miss_count_n;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (line_we) data_mem[idx] <= line_wdata;
    if (tag_we)  tag_mem[idx]  <= tag_in;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        req, req_we, flush;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic        ready, ack, hit;
  logic [15:0] rdata;
  logic [13:0] mem_addr;
  logic        mem_cs, mem_we, mem_oe;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] hit_count, miss_count;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready), .ack(ack), .rdata(rdata), .hit(hit),
    .flush(flush), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: address/controls sampled at the edge, read data after it.
  logic [15:0] ram [16384];
  logic [15:0] ram_q;
  logic        ram_init;
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= 16'(i) + 16'h1000;
      ram[14'h10B] <= 16'h0005;
    end else if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else if (mem_oe) ram_q <= ram[mem_addr];
    end
  end

  // Protocol monitor.
  int viol;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && mem_oe) viol++;
      if (ready && mem_cs) viol++;
    end
  end

  // Reference model: what the cache holds, what memory should hold, counters.
  logic        m_valid [16];
  logic [9:0]  m_tag   [16];
  logic [15:0] ref_mem [16384];
  int          m_hits, m_miss;

  int n_chk, n_fail;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic access(input logic we, input logic [13:0] a, input logic [15:0] wd,
                        output logic g_hit, output int g_lat, output logic [15:0] g_rd);
    logic [3:0]  ix;
    logic        e_hit;
    int          e_lat;
    logic [15:0] e_rd;
    int          w, we_cnt, oe_cnt;
    logic        got_ack;
    ix    = a[3:0];
    e_hit = m_valid[ix] && (m_tag[ix] == a[13:4]);
    e_lat = we ? 2 : (e_hit ? 1 : 3);
    e_rd  = ref_mem[a];
    if (we) ref_mem[a] = wd;
    else if (!e_hit) begin
      m_valid[ix] = 1'b1;
      m_tag[ix]   = a[13:4];
    end
    if (e_hit) m_hits = (m_hits < 65535) ? m_hits + 1 : 65535;
    else       m_miss = (m_miss < 65535) ? m_miss + 1 : 65535;

    @(negedge clk);
    w = 0;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    g_lat = 0; we_cnt = 0; oe_cnt = 0; got_ack = 1'b0;
    g_hit = 1'b0; g_rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (mem_we) begin
        we_cnt++;
        check("st_mem_addr", 32'(mem_addr), 32'(a));
        check("st_mem_wdata", 32'(mem_wdata), 32'(wd));
      end
      if (mem_oe) oe_cnt++;
      if (ack) begin
        got_ack = 1'b1;
        g_lat = c;
        g_hit = hit;
        g_rd  = rdata;
        break;
      end
    end
    check("ack_seen", 32'(got_ack), 32'd1);
    check("latency", 32'(g_lat), 32'(e_lat));
    check("hit", 32'(g_hit), 32'(e_hit));
    if (!we) check("rdata", 32'(g_rd), 32'(e_rd));
    check("we_cycles", 32'(we_cnt), we ? 32'd1 : 32'd0);
    check("oe_cycles", 32'(oe_cnt), (!we && !e_hit) ? 32'd2 : 32'd0);
    check("hit_count", 32'(hit_count), 32'(m_hits));
    check("miss_count", 32'(miss_count), 32'(m_miss));
  endtask

  task automatic do_flush(input logic with_req);
    int acks;
    @(negedge clk);
    flush = 1'b1; req = with_req; req_we = 1'b0; req_addr = 14'h10B;
    #1;
    check("flush_ready_low", 32'(ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ack || !ready) acks++;
      @(negedge clk);
    end
    check("flush_no_accept", 32'(acks), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic        exp_hit;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [11];
  logic        g_hit;
  int          g_lat;
  logic [15:0] g_rd;

  initial begin
    vecs[0]  = '{1'b0, 14'h10B, 16'h0000, 1'b0, 3, 16'h0005};
    vecs[1]  = '{1'b0, 14'h10B, 16'h0000, 1'b1, 1, 16'h0005};
    vecs[2]  = '{1'b0, 14'h10D, 16'h0000, 1'b0, 3, 16'h110D};
    vecs[3]  = '{1'b1, 14'h10D, 16'h0023, 1'b1, 2, 16'h0000};
    vecs[4]  = '{1'b0, 14'h10D, 16'h0000, 1'b1, 1, 16'h0023};
    vecs[5]  = '{1'b1, 14'h10E, 16'h0077, 1'b0, 2, 16'h0000};
    vecs[6]  = '{1'b0, 14'h10E, 16'h0000, 1'b0, 3, 16'h0077};
    vecs[7]  = '{1'b0, 14'h101, 16'h0000, 1'b0, 3, 16'h1101};
    vecs[8]  = '{1'b0, 14'h111, 16'h0000, 1'b0, 3, 16'h1111};
    vecs[9]  = '{1'b0, 14'h101, 16'h0000, 1'b0, 3, 16'h1101};
    vecs[10] = '{1'b0, 14'h101, 16'h0000, 1'b1, 1, 16'h1101};

    n_chk = 0; n_fail = 0; viol = 0;
    clk = 1'b0; rst = 1'b1; ram_init = 1'b1;
    req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'(i) + 16'h1000;
    ref_mem[14'h10B] = 16'h0005;
    model_reset();

    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    check("rst_ack_hit", {30'd0, ack, hit}, 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check("rst_mem_bus", {2'd0, mem_addr, mem_wdata}, 32'd0);
    check("rst_counters", {hit_count, miss_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      access(vecs[v].we, vecs[v].addr, vecs[v].wdata, g_hit, g_lat, g_rd);
      check($sformatf("vec%0d_hit", v), 32'(g_hit), 32'(vecs[v].exp_hit));
      check($sformatf("vec%0d_lat", v), 32'(g_lat), 32'(vecs[v].exp_lat));
      if (!vecs[v].we) check($sformatf("vec%0d_rdata", v), 32'(g_rd), 32'(vecs[v].exp_rdata));
    end
    check("table_hits", 32'(hit_count), 32'd4);
    check("table_misses", 32'(miss_count), 32'd7);
    check("ram_10D", 32'(ram[14'h10D]), 32'h0023);

    // Flush with a simultaneous request: not accepted, cached line goes cold.
    do_flush(1'b1);
    access(1'b0, 14'h10B, 16'h0, g_hit, g_lat, g_rd);
    check("post_flush_miss", 32'(g_hit), 32'd0);

    // Reset while the controller waits for RAM read data.
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 14'h120;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_ack_hit", {30'd0, ack, hit}, 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    check("midrst_mem_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check("midrst_counters", {hit_count, miss_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int acks;
      acks = 0;
      repeat (4) begin
        @(negedge clk);
        if (ack) acks++;
      end
      check("midrst_no_ack", 32'(acks), 32'd0);
    end
    access(1'b0, 14'h120, 16'h0, g_hit, g_lat, g_rd);
    check("post_rst_miss", 32'(g_hit), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [9:0]  tg;
      logic [13:0] a;
      if ($urandom_range(0, 15) == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 3))
          0: tg = 10'h010;
          1: tg = 10'h011;
          2: tg = 10'h3FF;
          default: tg = 10'h2A5;
        endcase
        a = {tg, 4'($urandom_range(0, 15))};
        access($urandom_range(0, 2) == 0, a, 16'($urandom), g_hit, g_lat, g_rd);
      end
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 16384; i++) if (ram[i] !== ref_mem[i]) bad++;
      check("ram_contents", 32'(bad), 32'd0);
    end
    check("protocol_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, write-no-allocate cache controller between the CPU fetch/execute sequencer and `single_port_sync_ram_large`.
- Owns the tag/valid/data arrays and sequences the RAM chip-select, write-enable and output-enable pins.
- Returns hit/miss status to the CPU and keeps saturating hit/miss counters for performance checks.
- Replaces the ad-hoc found/cwe/coe handling in the CPU sequencer.

Parameters:
- ADDR_WIDTH, 14, word address width (matches the RAM).
- DATA_WIDTH, 16, word width.
- INDEX_BITS, 4, line-index bits; LINES = 2**INDEX_BITS; tag = addr[ADDR_WIDTH-1:INDEX_BITS].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  CPU request strobe.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- ready  out  1  combinational: (state==IDLE) && !flush. A request is accepted on an edge where req && ready.
- ack  out  1  registered one-cycle completion pulse.
- rdata  out  DATA_WIDTH  load data; valid while ack=1 and held until the next ack.
- hit  out  1  registered, qualifies ack: 1 = access hit in the cache.
- flush  in  1  invalidate all lines.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_cs, mem_we, mem_oe  out  1 each  RAM control pins.
- mem_wdata  out  DATA_WIDTH  data driven onto the RAM bus when mem_we=1.
- mem_rdata  in  DATA_WIDTH  RAM bus read value.
- hit_count, miss_count  out  16 each  saturating performance counters.

Behaviour:
- Reset (async, rst=1): state=IDLE; all valid bits=0.
  - ack=0, hit=0, rdata=0.
  - mem_cs=0, mem_we=0, mem_oe=0, mem_addr=0, mem_wdata=0.
  - Both counters=0.
  - Tag and data arrays are not reset.
- RAM model: synchronous. Address and controls sampled at edge N; read data valid on mem_rdata after edge N, so it is sampled by the controller at edge N+1.
- States: IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR.
- IDLE:
  - On acceptance at edge E0: latch addr, we and wdata; go to LOOKUP.
  - flush=1 in IDLE: all valid bits cleared at that edge; no request is accepted that cycle (flush wins over req).
  - flush in any other state is ignored.
- LOOKUP (edge E1), hit = valid[index] && tag[index]==tag(addr):
  - Load hit: ack=1, hit=1, rdata=line data; hit_count++; go to IDLE. Latency is 1 edge after acceptance.
  - Load miss: mem_addr=addr, mem_cs=1, mem_oe=1, mem_we=0; miss_count++; go to MEM_RD.
  - Store, hit or miss: mem_addr=addr, mem_wdata=wdata, mem_cs=1, mem_we=1, mem_oe=0; go to MEM_WR.
  - Store hit updates the line data at E1; hit_count++.
  - Store miss does not allocate; miss_count++.
- MEM_RD (edge E2): RAM samples the address; hold controls; go to MEM_WAIT.
- MEM_WAIT (edge E3):
  - Capture mem_rdata into the line; set tag and valid.
  - ack=1, hit=0, rdata=mem_rdata.
  - Drop cs/oe; go to IDLE.
  - Read-miss latency is 3 edges after acceptance.
- MEM_WR (edge E2): RAM writes; ack=1; hit = the hit result from LOOKUP; drop cs/we; go to IDLE. Store latency is 2 edges.
- ack is high for exactly one cycle. The next request can be accepted at the edge that ends the ack cycle.
- mem_we and mem_oe are never both 1. mem_cs=0 whenever the controller is idle.
- Counters saturate at 16'hFFFF and do not wrap.
- rst mid-transaction: immediate return to reset values. The in-flight access is dropped with no ack. A RAM write already sampled may complete. All lines become invalid.
- Address aliasing: addresses differing only in tag bits evict each other. A load miss overwrites the line unconditionally; there is no dirty state because the cache is write-through.

Test Plan:
- Cold load of 'h10B (RAM holds 'h0005) -> ack at E0+3, hit=0, rdata='h0005, miss_count=1. Repeat the load -> ack at E0+1, hit=1, rdata='h0005, hit_count=1.
- Store 'h0023 to 'h10D after loading 'h10D -> mem_we=1 for one cycle at mem_addr='h10D; ack at E0+2, hit=1. Reload 'h10D hits with 'h0023, and RAM also holds 'h0023.
- Store to uncached 'h10E, then load 'h10E -> store hit=0 with no allocation; the load misses and returns the stored value from RAM.
- Conflict: load 'h101 then load 'h111 (same index, different tag) -> both miss. Load 'h101 again -> miss, and the line refills with 'h101's data.
- Flush asserted with req high in IDLE -> ready=0 and the request is not accepted. The next load of a previously cached address misses.
- Assert rst during MEM_WAIT -> no ack; all outputs and counters read 0; mem_cs=0. The next load of the same address misses.
